// File: rtl/cache_arb_pkg.sv
// Shared types for the cache fill arbiter.
// States, requester ids and default block geometry.
package cache_arb_pkg;

  localparam int WORDS_DEF      = 8;
  localparam int WORD_BYTES_DEF = 2;
  localparam int BLOCK_BYTES    = WORDS_DEF * WORD_BYTES_DEF;
  localparam int OFFSET_W       = $clog2(BLOCK_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    FILL_I,
    FILL_D,
    DONE_I,
    DONE_D
  } arb_state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } requester_t;

  function automatic requester_t state_req(arb_state_t s);
    return (s == FILL_D || s == DONE_D) ? REQ_D : REQ_I;
  endfunction

endpackage

// File: rtl/fill_word_counter.sv
// Word counter for block fills: sync clear, increment, end flag.
// Ports: clk, rst, clr, inc in; count, last (count == LAST) out.
module fill_word_counter #(
  parameter int CW   = 3,
  parameter int LAST = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          last
);

  always_ff @(posedge clk) begin
    if (rst || clr)
      count <= '0;
    else if (inc)
      count <= count + CW'(1);
  end

  assign last = (count == CW'(LAST));

endmodule

// File: rtl/cache_fill_arbiter.sv
// Arbitrates main memory between I/D-cache miss fills; D wins ties.
// In: clk, rst, i/d_miss(+addr), mem_data_valid, mem_data.
// Out: mem_en/addr, fill_data/word, i/d_fill_we, i/d_fill_done, i/d_busy.
module cache_fill_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_BLOCK = WORDS_DEF,
  parameter int WORD_BYTES      = WORD_BYTES_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_miss,
  input  logic [ADDR_W-1:0]                  i_miss_addr,
  input  logic                               d_miss,
  input  logic [ADDR_W-1:0]                  d_miss_addr,
  output logic                               mem_en,
  output logic [ADDR_W-1:0]                  mem_addr,
  input  logic                               mem_data_valid,
  input  logic [DATA_W-1:0]                  mem_data,
  output logic [DATA_W-1:0]                  fill_data,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
  output logic                               i_fill_we,
  output logic                               d_fill_we,
  output logic                               i_fill_done,
  output logic                               d_fill_done,
  output logic                               i_busy,
  output logic                               d_busy
);

  localparam int WW = $clog2(WORDS_PER_BLOCK);
  localparam int OW = $clog2(WORDS_PER_BLOCK * WORD_BYTES);

  arb_state_t        state, state_nxt;
  requester_t        req;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] sel_addr;
  logic [WW:0]       issue_cnt;
  logic [WW-1:0]     recv_cnt;
  logic              issue_end;
  logic              recv_last;
  logic              in_fill;
  logic              issue_act;
  logic              recv_act;
  logic              leave_idle;

  assign in_fill    = (state == FILL_I) || (state == FILL_D);
  assign req        = state_req(state);
  assign issue_act  = in_fill && !issue_end;
  assign recv_act   = in_fill && mem_data_valid;
  assign leave_idle = (state == IDLE) && (i_miss || d_miss);
  assign sel_addr   = d_miss ? d_miss_addr : i_miss_addr;

  // Issue counter runs one past the last word so it can flag "all sent".
  fill_word_counter #(
    .CW   (WW + 1),
    .LAST (WORDS_PER_BLOCK)
  ) u_issue_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (state == IDLE),
    .inc   (issue_act),
    .count (issue_cnt),
    .last  (issue_end)
  );

  fill_word_counter #(
    .CW   (WW),
    .LAST (WORDS_PER_BLOCK - 1)
  ) u_recv_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (state == IDLE),
    .inc   (recv_act),
    .count (recv_cnt),
    .last  (recv_last)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst)
      base <= '0;
    else if (leave_idle)
      base <= {sel_addr[ADDR_W-1:OW], {OW{1'b0}}};
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (d_miss)
          state_nxt = FILL_D;
        else if (i_miss)
          state_nxt = FILL_I;
      end
      FILL_I: begin
        if (recv_act && recv_last)
          state_nxt = DONE_I;
      end
      FILL_D: begin
        if (recv_act && recv_last)
          state_nxt = DONE_D;
      end
      DONE_I,
      DONE_D:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_en   = issue_act;
  assign mem_addr = issue_act
    ? base + ADDR_W'(issue_cnt) * ADDR_W'(WORD_BYTES)
    : '0;

  // Return path is combinational so the cache writes in the arrival cycle.
  assign fill_data   = recv_act ? mem_data : '0;
  assign fill_word   = recv_act ? recv_cnt : '0;
  assign i_fill_we   = recv_act && (req == REQ_I);
  assign d_fill_we   = recv_act && (req == REQ_D);

  assign i_fill_done = (state == DONE_I);
  assign d_fill_done = (state == DONE_D);
  assign i_busy      = (state == FILL_I) || (state == DONE_I);
  assign d_busy      = (state == FILL_D) || (state == DONE_D);

endmodule
